// File: rtl/pwm_adc_pkg.sv
// Shared types and constants for the soc/eoc-driven multi-channel PWM block.
package pwm_adc_pkg;

    localparam int STATE_W        = 2;
    localparam int DEFAULT_PERIOD = 255;

    typedef enum logic [STATE_W-1:0] {
        S_SOC   = 2'd0,
        S_WAIT  = 2'd1,
        S_LATCH = 2'd2
    } conv_state_t;

    // Channel pointer width; a single channel still needs one bit.
    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: double-buffered duty (shadow + active) and a registered output.
module pwm_channel #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset_,
    input  logic [W-1:0] cnt,
    input  logic         load,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    output logic         out
);

    logic [W-1:0] duty_sh;
    logic [W-1:0] duty_act;

    // NOTE: non-blocking assignments here make a write and a load in the same
    // edge transfer the old shadow value, so the new duty waits a full period.
    // NOTE: these duty registers are ordinary flops, so they take the async
    // reset; only a RAM-style array would be left unreset.
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            duty_sh  <= '0;
            duty_act <= '0;
            out      <= 1'b0;
        end else begin
            if (wr_en) duty_sh <= wr_data;
            if (load)  duty_act <= duty_sh;
            out <= (cnt < duty_act);
        end
    end

endmodule

// File: rtl/pwm_adc_scan.sv
// Round-robin A/D scan over N channels feeding N double-buffered PWM outputs;
// duties change only at the period boundary.
module pwm_adc_scan
    import pwm_adc_pkg::*;
#(
    parameter int W      = 8,
    parameter int N      = 4,
    parameter int PERIOD = DEFAULT_PERIOD
) (
    input  logic                 clock,
    input  logic                 reset_,
    input  logic                 eoc,
    input  logic [W-1:0]         numero,
    output logic                 soc,
    output logic [chan_w(N)-1:0] chan,
    output logic [N-1:0]         out
);

    localparam int           CW       = chan_w(N);
    localparam logic [W-1:0] PERIOD_V = W'(PERIOD);
    localparam logic [W-1:0] CNT_LAST = W'(PERIOD - 1);

    logic [W-1:0] cnt;
    logic         boundary;
    logic [W-1:0] duty_wr;

    conv_state_t state, state_next;
    logic        latch;
    logic        soc_next;

    assign boundary = (cnt == CNT_LAST);
    assign duty_wr  = (numero > PERIOD_V) ? PERIOD_V : numero;

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_)       cnt <= '0;
        else if (boundary) cnt <= '0;
        else               cnt <= cnt + 1'b1;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        latch      = 1'b0;
        soc_next   = (state == S_SOC);
        case (state)
            S_SOC:   if (!eoc) state_next = S_WAIT;
            S_WAIT:  if (eoc)  state_next = S_LATCH;
            S_LATCH: begin
                latch      = 1'b1;
                state_next = S_SOC;
            end
            default: state_next = S_SOC;
        endcase
    end

    // soc lags the state by one edge, giving the converter a full cycle of soc.
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state <= S_SOC;
            soc   <= 1'b0;
            chan  <= '0;
        end else begin
            state <= state_next;
            soc   <= soc_next;
            if (latch) chan <= (chan == CW'(N - 1)) ? '0 : chan + 1'b1;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        pwm_channel #(.W(W)) u_ch (
            .clock   (clock),
            .reset_  (reset_),
            .cnt     (cnt),
            .load    (boundary),
            .wr_en   (latch && (chan == CW'(i))),
            .wr_data (duty_wr),
            .out     (out[i])
        );
    end

endmodule
